// File: rtl/mips_instruction_encoder_pkg.sv
// ----------------------------------------------------------------------------
// mips_instruction_encoder_pkg
// Shared types and constants for the MIPS instruction encoder:
//   - opcode_e        : primary opcode values recognised by the encoder
//   - funct_e         : R-format funct codes that get canonical field forcing
//   - branch_mode_e   : legal rt values (branch modes) for opcode REGIMM
//   - instr_format_e  : encoding format chosen for a request
//   - enc_req_t       : field-level instruction request
//   - NOP_WORD/RFE_WORD and the bit position of every instruction field
//   - funct_supported : membership test for the supported R-format funct set
// ----------------------------------------------------------------------------
package mips_instruction_encoder_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDI    = 6'h08,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_COP0    = 6'h10,
    OP_COP1    = 6'h11,
    OP_LB      = 6'h20,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SWR     = 6'h2E,
    OP_LWC1    = 6'h31,
    OP_SWC1    = 6'h39
  } opcode_e;

  typedef enum logic [5:0] {
    FUNCT_SLL  = 6'h00,
    FUNCT_JR   = 6'h08,
    FUNCT_JALR = 6'h09,
    FUNCT_ADD  = 6'h20
  } funct_e;

  typedef enum logic [4:0] {
    BR_BLTZ   = 5'd0,
    BR_BGEZ   = 5'd1,
    BR_BLTZAL = 5'd16,
    BR_BGEZAL = 5'd17
  } branch_mode_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J,
    FMT_ILLEGAL
  } instr_format_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RFE_WORD = 32'h4200_0010;
  localparam logic [4:0]  LINK_REG = 5'd31;

  // Least-significant bit position of each field in the 32-bit word.
  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } enc_req_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    return funct inside {6'h00, [6'h02:6'h04], [6'h06:6'h09], 6'h0D,
                         [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27],
                         6'h2A, 6'h2B};
  endfunction

endpackage

// File: rtl/mips_instruction_encoder_encode_comb.sv
// ----------------------------------------------------------------------------
// mips_encode_comb
// Purely combinational request -> instruction word encoder.
//   req     : field-level request (enc_req_t)
//   word    : packed 32-bit instruction, NOP_WORD when the request is illegal
//   illegal : request could not be encoded as a legal instruction
// Canonical forcing: JR/JALR zero their unused fields, JALR defaults rd to the
// link register, LUI zeroes rs, BLEZ/BGTZ zero rt.
// ----------------------------------------------------------------------------
module mips_encode_comb
  import mips_instruction_encoder_pkg::*;
#(
  parameter bit CHECK_FUNCT = 1'b1
) (
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  instr_format_e fmt;
  logic          is_rfe;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fmt    = FMT_ILLEGAL;
    is_rfe = 1'b0;
    rs     = req.rs;
    rt     = req.rt;
    rd     = req.rd;
    shamt  = req.shamt;

    case (req.opcode)
      OP_SPECIAL: begin
        if (!CHECK_FUNCT || funct_supported(req.funct)) fmt = FMT_R;
        if (req.funct == FUNCT_JR) begin
          rt    = '0;
          rd    = '0;
          shamt = '0;
        end else if (req.funct == FUNCT_JALR) begin
          rt    = '0;
          shamt = '0;
          if (req.rd == '0) rd = LINK_REG;
        end
      end
      OP_J, OP_JAL: fmt = FMT_J;
      OP_REGIMM: begin
        if (req.rt inside {BR_BLTZ, BR_BGEZ, BR_BLTZAL, BR_BGEZAL}) fmt = FMT_I;
      end
      OP_BLEZ, OP_BGTZ: begin
        fmt = FMT_I;
        rt  = '0;
      end
      OP_LUI: begin
        fmt = FMT_I;
        rs  = '0;
      end
      OP_COP0: begin
        fmt    = FMT_R;
        is_rfe = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI: fmt = FMT_I;
      default: begin
        if (req.opcode inside {[OP_LB:OP_LWR], [OP_SB:OP_SWR], OP_LWC1, OP_SWC1})
          fmt = FMT_I;
      end
    endcase
  end

  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OP_LSB +: 6]    = req.opcode;
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[RD_LSB +: 5]    = rd;
        word[SHAMT_LSB +: 5] = shamt;
        word[FUNCT_LSB +: 6] = req.funct;
      end
      FMT_I: begin
        word[OP_LSB +: 6]   = req.opcode;
        word[RS_LSB +: 5]   = rs;
        word[RT_LSB +: 5]   = rt;
        word[IMM_LSB +: 16] = req.imm;
      end
      FMT_J: begin
        word[OP_LSB +: 6]      = req.opcode;
        word[TARGET_LSB +: 26] = req.target;
      end
      default: illegal = 1'b1;
    endcase
    // RFE is a fixed coprocessor-0 word regardless of the request fields.
    if (is_rfe) word = RFE_WORD;
  end

endmodule

// File: rtl/mips_instruction_encoder.sv
// ----------------------------------------------------------------------------
// mips_instruction_encoder
// Two-stage valid/ready pipeline that packs field-level requests into legal
// 32-bit MIPS words. S1 holds the raw request, S2 the encoded word.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake
//   req_opcode .. req_target : request fields
//   out_valid / out_ready    : output handshake
//   out_instruction          : encoded word (32'h0 for an illegal request)
//   out_illegal              : word substitutes an illegal request
//   illegal_count            : saturating count of illegal requests encoded
// ----------------------------------------------------------------------------
module mips_instruction_encoder
  import mips_instruction_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter bit CHECK_FUNCT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [5:0]             req_opcode,
  input  logic [4:0]             req_rs,
  input  logic [4:0]             req_rt,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_shamt,
  input  logic [5:0]             req_funct,
  input  logic [15:0]            req_imm,
  input  logic [25:0]            req_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instruction,
  output logic                   out_illegal,
  output logic [COUNT_WIDTH-1:0] illegal_count
);

  logic        s1_valid;
  enc_req_t    s1_req;
  logic        s2_adv;
  logic        accept;
  logic [31:0] enc_word;
  logic        enc_illegal;

  assign s2_adv    = !out_valid || out_ready;
  assign req_ready = !rst && (!s1_valid || s2_adv);
  assign accept    = req_valid && req_ready;

  // NOTE: the S1 payload has no reset; s1_valid alone qualifies it, so the
  // wide data register stays a plain enable flop.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_req <= '{opcode: req_opcode, rs: req_rs, rt: req_rt, rd: req_rd,
                  shamt: req_shamt, funct: req_funct, imm: req_imm,
                  target: req_target};
    end
  end

  mips_encode_comb #(
    .CHECK_FUNCT (CHECK_FUNCT)
  ) u_encode (
    .req     (s1_req),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_illegal     <= 1'b0;
      illegal_count   <= '0;
    end else begin
      // When S1 can take a new entry it is either empty or draining into S2
      // this cycle, so its next occupancy is simply req_valid.
      if (req_ready) s1_valid <= req_valid;

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instruction <= enc_word;
          out_illegal     <= enc_illegal;
          if (enc_illegal && (illegal_count != '1))
            illegal_count <= illegal_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_instruction_encoder.sv
// ----------------------------------------------------------------------------
// Self-checking bench for mips_instruction_encoder. A field-rule model turns
// each accepted request into its expected word; a scoreboard queue tracks
// in-flight words and a negedge compare process checks every output.
// A 3-bit illegal_count makes saturation reachable.
// ----------------------------------------------------------------------------
module tb_mips_instruction_encoder;

  localparam int CW = 3;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  typedef struct {
    logic [31:0] word;
    logic        ill;
    int          edge_no;
    bit          shown;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [5:0]    req_opcode = '0;
  logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [5:0]    req_funct = '0;
  logic [15:0]   req_imm = '0;
  logic [25:0]   req_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instruction;
  logic          out_illegal;
  logic [CW-1:0] illegal_count;

  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_count = 0;
  int   ill_entered = 0;
  exp_t q[$];
  bit   rand_or = 0;
  bit   or_dir = 1;
  bit   exp_v;
  int   exp_cnt;

  logic [5:0] legal_ops [16] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h23, 6'h2B, 6'h31};
  logic [5:0] common_functs [6] = '{6'h00, 6'h08, 6'h09, 6'h20, 6'h2A, 6'h1A};
  logic [4:0] modes [4] = '{5'd0, 5'd1, 5'd16, 5'd17};

  always #5 clk = ~clk;

  mips_instruction_encoder #(
    .COUNT_WIDTH (CW),
    .CHECK_FUNCT (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_opcode      (req_opcode),
    .req_rs          (req_rs),
    .req_rt          (req_rt),
    .req_rd          (req_rd),
    .req_shamt       (req_shamt),
    .req_funct       (req_funct),
    .req_imm         (req_imm),
    .req_target      (req_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_illegal     (out_illegal),
    .illegal_count   (illegal_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] f);
    int v = int'(f);
    return (v == 0) || (v >= 2 && v <= 4) || (v >= 6 && v <= 9) || (v == 13) ||
           (v >= 16 && v <= 19) || (v >= 24 && v <= 27) || (v >= 32 && v <= 39) ||
           (v == 42) || (v == 43);
  endfunction

  // Encoding rules written straight from the instruction-format table.
  function automatic logic [31:0] model(input req_t r, output logic ill);
    int         op = int'(r.op);
    logic [4:0] rt = r.rt;
    logic [4:0] rd = r.rd;
    logic [4:0] sh = r.shamt;
    ill = 1'b0;
    if (op == 0) begin
      if (!funct_ok(r.funct)) begin ill = 1'b1; return 32'h0; end
      if (r.funct == 6'h08) begin rt = 0; rd = 0; sh = 0; end
      else if (r.funct == 6'h09) begin rt = 0; sh = 0; if (rd == 0) rd = 5'd31; end
      return {r.op, r.rs, rt, rd, sh, r.funct};
    end
    if (op == 2 || op == 3) return {r.op, r.target};
    if (op == 16) return 32'h42000010;
    if (op == 1) begin
      if (!(r.rt inside {5'd0, 5'd1, 5'd16, 5'd17})) begin ill = 1'b1; return 32'h0; end
      return {r.op, r.rs, r.rt, r.imm};
    end
    if (op == 6 || op == 7) return {r.op, r.rs, 5'd0, r.imm};
    if (op == 15) return {r.op, 5'd0, r.rt, r.imm};
    if (op inside {4, 5, [8:14], [32:38], [40:46], 49, 57}) return {r.op, r.rs, r.rt, r.imm};
    ill = 1'b1;
    return 32'h0;
  endfunction

  function automatic req_t mk(input int op, input int rs, input int rt, input int rd,
                              input int sh, input int f, input int imm, input int tgt);
    req_t r;
    r.op = 6'(op); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.shamt = 5'(sh);
    r.funct = 6'(f); r.imm = 16'(imm); r.target = 26'(tgt);
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   sel = $urandom_range(0, 9);
    r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
    r.shamt = 5'($urandom); r.funct = 6'($urandom);
    r.imm = 16'($urandom); r.target = 26'($urandom);
    if (sel <= 1) r.op = 6'($urandom);
    else if (sel <= 4) begin
      r.op = 6'h00;
      if ($urandom_range(0, 3) != 0) r.funct = common_functs[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) r.rd = 5'd0;
    end else if (sel == 5) begin
      r.op = 6'h01;
      if ($urandom_range(0, 1) == 0) r.rt = modes[$urandom_range(0, 3)];
    end else if (sel == 6) r.op = 6'($urandom_range(2, 3));
    else r.op = legal_ops[$urandom_range(0, 15)];
    return r;
  endfunction

  // Output handshake driver: random in the random phase, directed otherwise.
  always @(posedge clk) begin
    #2;
    out_ready = rand_or ? ($urandom_range(0, 9) < 7) : or_dir;
  end

  always @(posedge clk) edge_count++;

  // Scoreboard / compare process.
  always @(negedge clk) begin
    if (rst) begin
      check("req_ready_in_reset", 32'(req_ready), 32'h0);
      q.delete();
      ill_entered = 0;
    end else begin
      exp_v = (q.size() > 0) && (q[0].edge_no < edge_count);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("req_ready", 32'(req_ready), 32'((q.size() < 2) || out_ready));
      if (exp_v) begin
        if (!q[0].shown) begin
          q[0].shown = 1;
          if (q[0].ill) ill_entered++;
        end
        check("out_instruction", out_instruction, q[0].word);
        check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      exp_cnt = (ill_entered > (2 ** CW - 1)) ? (2 ** CW - 1) : ill_entered;
      check("illegal_count", 32'(illegal_count), 32'(exp_cnt));
      if (exp_v && out_ready) void'(q.pop_front());
      if (req_valid && req_ready) begin
        exp_t e;
        req_t r;
        r.op = req_opcode; r.rs = req_rs; r.rt = req_rt; r.rd = req_rd;
        r.shamt = req_shamt; r.funct = req_funct; r.imm = req_imm; r.target = req_target;
        e.word = model(r, e.ill);
        e.edge_no = edge_count + 1;
        e.shown = 0;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input req_t r);
    req_opcode = r.op; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
    req_shamt = r.shamt; req_funct = r.funct; req_imm = r.imm; req_target = r.target;
  endtask

  // Presents a request and returns 1 time unit after the accepting edge.
  task automatic send(input req_t r);
    bit acc = 0;
    drive(r);
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("send_accept_timeout", 32'(acc), 32'h1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic ill;
    logic [31:0] w;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instruction", out_instruction, 32'h0);
    check("rst_out_illegal", 32'(out_illegal), 32'h0);
    check("rst_illegal_count", 32'(illegal_count), 32'h0);

    // Hand-computed words that pin the model.
    w = model(mk(8, 2, 3, 0, 0, 0, 16'hFFFC, 0), ill);   check("model_addi", w, 32'h2043FFFC);
    w = model(mk(0, 1, 2, 3, 0, 6'h20, 0, 0), ill);      check("model_add", w, 32'h00221820);
    w = model(mk(3, 0, 0, 0, 0, 0, 0, 26'h0100000), ill); check("model_jal", w, 32'h0C100000);
    w = model(mk(15, 5, 8, 0, 0, 0, 16'h1234, 0), ill);  check("model_lui", w, 32'h3C081234);
    w = model(mk(0, 4, 0, 0, 0, 6'h09, 0, 0), ill);      check("model_jalr", w, 32'h0080F809);
    w = model(mk(1, 0, 5, 0, 0, 0, 0, 0), ill);          check("model_bad_branch", 32'(ill), 32'h1);

    // ADDI: valid two edges after accept.
    send(mk(8, 2, 3, 0, 0, 0, 16'hFFFC, 0));
    check("addi_latency_valid", 32'(out_valid), 32'h0);
    idle(1);
    check("addi_valid", 32'(out_valid), 32'h1);
    check("addi_word", out_instruction, 32'h2043FFFC);
    check("addi_illegal", 32'(out_illegal), 32'h0);

    send(mk(0, 1, 2, 3, 0, 6'h20, 0, 0));
    send(mk(3, 0, 0, 0, 0, 0, 0, 26'h0100000));
    send(mk(15, 5, 8, 0, 0, 0, 16'h1234, 0));
    send(mk(0, 4, 7, 0, 3, 6'h09, 0, 0));
    send(mk(16, 9, 9, 9, 9, 6'h3F, 16'hFFFF, 0));
    send(mk(6'h11, 1, 1, 1, 1, 1, 1, 1));   // COP1 is illegal: count -> 1
    idle(3);

    // Two further illegal requests.
    send(mk(6'h3F, 1, 2, 3, 4, 5, 6, 7));
    send(mk(1, 0, 5, 0, 0, 0, 16'h0010, 0));
    idle(3);
    check("illegal_count_3", 32'(illegal_count), 32'h3);

    // Backpressure: only two accepts, first word held stable.
    or_dir = 0;
    idle(1);
    send(mk(0, 1, 2, 3, 0, 6'h20, 0, 0));
    send(mk(3, 0, 0, 0, 0, 0, 0, 26'h0100000));
    drive(mk(15, 5, 8, 0, 0, 0, 16'h1234, 0));
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready_low", 32'(req_ready), 32'h0);
      check("bp_word1_held", out_instruction, 32'h00221820);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 or_dir = 1;
    send(mk(15, 5, 8, 0, 0, 0, 16'h1234, 0));
    idle(4);

    // Reset with both stages full (S2 holds an illegal word).
    or_dir = 0;
    idle(1);
    send(mk(6'h3F, 0, 0, 0, 0, 0, 0, 0));
    send(mk(8, 1, 1, 0, 0, 0, 16'h0001, 0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    or_dir = 1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_illegal_count", 32'(illegal_count), 32'h0);
    send(mk(0, 4, 0, 0, 0, 6'h09, 0, 0));
    idle(1);
    check("post_rst_jalr", out_instruction, 32'h0080F809);
    idle(2);

    // Randomized traffic with random backpressure; drives the counter into
    // saturation along the way.
    rand_or = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(rand_req());
    end
    rand_or = 0;
    or_dir = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) idle(1);
    check("drain_empty", 32'(q.size()), 32'h0);
    check("count_saturated", 32'(illegal_count), 32'(2 ** CW - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instruction_encoder.md
Name: mips_instruction_encoder

Overview:
- Inverse of the control decoder: takes a field-level instruction request and packs it into a legal 32-bit MIPS word in R, I or J format.
- Output word goes to instruction memory, and from there to the decoder.
- Used by the debug/boot injector and the self-test sequencer.
- Two-stage valid/ready pipeline with full throughput, canonical field forcing, illegal-request detection and a saturating error counter.

Parameters:
- COUNT_WIDTH, 16, width of illegal_count.
- CHECK_FUNCT, 1, when 1 an R-format funct outside the supported set is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  encoder accepts request this cycle
- req_opcode  in  6  OPCode value
- req_rs  in  5  source register
- req_rt  in  5  target register, or branch mode for opcode 6'h1
- req_rd  in  5  destination register
- req_shamt  in  5  shift amount
- req_funct  in  6  ALU funct
- req_imm  in  16  immediate / branch offset
- req_target  in  26  jump target
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instruction  out  32  encoded word
- out_illegal  out  1  word is a substituted NOP for an illegal request
- illegal_count  out  COUNT_WIDTH  saturating count of illegal requests accepted

Behaviour:
- Reset values: all outputs 0, both stage valids 0, req_ready 0 during the reset cycle.
- Pipeline registers:
  - Stage S1 holds the raw request.
  - Stage S2 holds the encoded word, out_illegal and out_valid.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - req_ready = !s1_valid || s2_adv.
  - Accept on req_valid && req_ready.
  - S1 moves to S2 when s1_valid && s2_adv.
  - Latency: 2 cycles from accept to out_valid. One word per cycle when out_ready stays high.
  - Outputs are held stable while out_valid && !out_ready. No loss, no duplication, order preserved.
- R format (opcode 6'h0): {op, rs, rt, rd, shamt, funct}.
  - JR: rt = rd = shamt = 0.
  - JALR: rt = shamt = 0; rd = 31 if req_rd == 0.
  - funct 6'h0 with all fields 0 is NOP, giving 32'h0.
  - Supported funct set: 0x00, 0x02–0x04, 0x06–0x09, 0x0D, 0x10–0x13, 0x18–0x1B, 0x20–0x27, 0x2A, 0x2B.
- J format (opcodes 2, 3): {op, target}.
- I format: {op, rs, rt, imm} for:
  - ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU
  - BEQ, BNE
  - loads 0x20–0x26
  - stores 0x28–0x2E
  - LWC1, SWC1
- Forced fields in I format:
  - LUI: rs = 0.
  - BGTZ/BLEZ: rt = 0.
  - Opcode 6'h1: rt must be 0, 1, 16 or 17 (BLTZ, BGEZ, BLTZAL, BGEZAL), else illegal.
- RFE: encoded as 32'h42000010.
- Illegal request (any other opcode, including 6'h11, bad branch mode, or bad funct with CHECK_FUNCT = 1):
  - S2 word = 32'h0, out_illegal = 1.
  - illegal_count increments on the S1→S2 transfer and saturates at all-ones.
- Width rules:
  - All fields are taken literally with no sign handling; imm passes through unchanged.
  - Only the 26 LSBs of the target are used.
- Reset mid-operation: both stages flushed, the in-flight word is dropped, counter cleared.

Decomposition:
- Opcode enum from MIPSInstructionPackage.
- ALU funct codes and branch-mode constants from ALUFunctCodesPackage and BranchModesPackage.
- New package EncoderPackage holds:
  - InstrFormat enum {FMT_R, FMT_I, FMT_J, FMT_ILLEGAL}.
  - Constants NOP_WORD and RFE_WORD.
  - Bit-position constants for each field.
- Sub-module mips_encode_comb: purely combinational request→{word, illegal}. Instantiated between S1 and S2.

Test Plan:
- ADDI, rs=2, rt=3, imm=16'hFFFC, out_ready=1 → 2 cycles later out_instruction = 32'h2043FFFC, out_illegal = 0.
- ADD (opcode 0), rs=1, rt=2, rd=3, funct=6'h20 → 32'h00221820. JAL, target=26'h0100000 → 32'h0C100000.
- LUI, rs=5, rt=8, imm=16'h1234 → 32'h3C081234 (rs forced to 0). JALR, rs=4, rd=0 → 32'h0080F809.
- Opcode 6'h3F, then opcode 6'h1 with rt=5 → two words of 32'h0 with out_illegal = 1; illegal_count = 2. Preloaded count of all-ones stays all-ones.
- Backpressure: 3 back-to-back requests with out_ready = 0 for 5 cycles → req_ready drops after 2 accepts, word 1 held stable. After release, words emerge in order, one per cycle, no loss.
- Assert rst while S1 and S2 are full → next cycle out_valid = 0, illegal_count = 0. The first request after reset is encoded normally.
